sma_crossover_detector: RTL
===========================

Name: sma_crossover_detector

Overview:
- Sits directly downstream of the SMA stage in SeriesPreprocessing.
- Consumes each raw Q8.8 sample together with its time-aligned Q8.8 moving average.
- Computes the signed deviation and tracks which side of the average the series is on, using a hysteresis band and N-sample confirmation.
- Emits registered cross-up/cross-down event pulses, a deviation stream and a saturating event counter for the feature-extraction stages.

Parameters:
- WARMUP, 8: number of initial valid samples discarded while the upstream SMA window fills (0 = no warmup).
- CONFIRM, 2: consecutive qualifying samples required to establish or change side (>=1).
- HYST, 16'h0020: hysteresis half-width, Q8.8 unsigned (0.125).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  one-cycle strobe; price_in/sma_in valid
- price_in  in  16  raw sample, Q8.8 unsigned
- sma_in  in  16  moving average aligned to price_in, Q8.8 unsigned
- out_valid  out  1  one-cycle pulse; diff_out/trend updated
- diff_out  out  16  price_in - sma_in, Q8.8 signed, saturated
- trend  out  2  00 unknown, 01 above, 10 below (11 never driven)
- cross_up  out  1  one-cycle pulse on confirmed BELOW->ABOVE
- cross_down  out  1  one-cycle pulse on confirmed ABOVE->BELOW
- event_count  out  16  total crossings since reset, saturates at 16'hFFFF

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0, state=WARMUP, warmup and confirm counters cleared.
  - rst wins over a simultaneous in_valid.
  - Reset mid-confirmation discards the partial count and restarts warmup.
- Arithmetic:
  - diff17 = {0,price_in} - {0,sma_in}, 17-bit signed.
  - above_q = diff17 > +HYST; below_q = diff17 < -HYST (HYST zero-extended).
  - |diff17| == HYST is in-band.
  - diff_out = diff17 clamped to [16'h8000, 16'h7FFF].
- Cycles with in_valid=0 change nothing: counters hold and outputs except pulses hold.
- States:
  - WARMUP:
    - Each valid sample increments the warmup count.
    - Sample number WARMUP is the last one discarded; the next cycle enters SEEK.
    - No out_valid is asserted in WARMUP.
    - WARMUP=0 resets directly into SEEK.
  - SEEK:
    - Every valid sample asserts out_valid.
    - above_q increments the up-count and clears the down-count; below_q does the reverse; in-band clears both.
    - When a count reaches CONFIRM, go to ABOVE/BELOW and set trend. No cross pulse and no event_count change (initial side establishment).
  - ABOVE:
    - below_q increments the down-count; any other valid sample clears it.
    - When the count reaches CONFIRM: go to BELOW, trend=10, cross_down=1, event_count++.
  - BELOW: mirror of ABOVE, with cross_up and trend=01.
- Timing:
  - All outputs are registered with latency 1 clk from the accepted in_valid edge.
  - out_valid, cross_up and cross_down are high for exactly one cycle.
  - cross_up and cross_down are never both high.
- Counters:
  - The confirm counter is wide enough for CONFIRM and never exceeds it.
  - CONFIRM=1 switches on the first qualifying sample.
  - event_count holds at 16'hFFFF, and pulses still fire at saturation.
- Back-to-back in_valid on every cycle is supported with no bubbles.

Test Plan:
- Warmup and establish: defaults, 8 valid samples with price=0x0500, sma=0x0100 → no out_valid, trend=00. Sample 9 → out_valid, diff_out=0x0400, trend=00. Sample 10 → trend=01, no cross pulse, event_count=0.
- Cross down: from ABOVE, two samples with price=0x0100, sma=0x0140 (diff=-0x0040) → cross_down pulse one cycle after the second sample, trend=10, event_count=1. Then two samples with diff=+0x0040 → cross_up, event_count=2.
- Hysteresis and interruption:
  - In ABOVE, repeated diff=-0x0020 (exactly -HYST) → no transition.
  - Sequence diff=-0x0040, -0x0010, -0x0040 → no event; one more -0x0040 → cross_down.
- Idle gaps: the two confirming samples separated by 5 cycles of in_valid=0 → transition still occurs on the second; out_valid pulses only on valid samples.
- Saturation:
  - price=0xFFFF, sma=0x0000 → diff_out=0x7FFF.
  - price=0x0000, sma=0xFFFF → diff_out=0x8000.
  - Force 65536 crossings with CONFIRM=1 → event_count stays 0xFFFF and pulses continue.
- Reset mid-operation: in ABOVE with one below_q sample pending, assert rst together with in_valid → next cycle all outputs 0, trend=00. 8 further samples are again suppressed before out_valid resumes.

Source files
------------

// File: rtl/sma_crossover_detector_if.sv
// Sample/average input stream and crossover event outputs of the SMA crossover detector.
// The master side feeds samples and observes events; the detector itself is the slave.
interface sma_crossover_detector_if;
    logic        in_valid;
    logic [15:0] price_in;
    logic [15:0] sma_in;
    logic        out_valid;
    logic [15:0] diff_out;
    logic [1:0]  trend;
    logic        cross_up;
    logic        cross_down;
    logic [15:0] event_count;

    modport master (
        output in_valid, price_in, sma_in,
        input  out_valid, diff_out, trend, cross_up, cross_down, event_count
    );

    modport slave (
        input  in_valid, price_in, sma_in,
        output out_valid, diff_out, trend, cross_up, cross_down, event_count
    );
endinterface

// File: rtl/sma_crossover_detector.sv
// Tracks which side of its moving average a Q8.8 series sits on, using a hysteresis band and
// N-sample confirmation, and reports confirmed crossings as registered pulses plus a count.
module sma_crossover_detector #(
    parameter int          WARMUP  = 8,
    parameter int          CONFIRM = 2,
    parameter logic [15:0] HYST    = 16'h0020
) (
    input  logic                     clk,
    input  logic                     rst,
    sma_crossover_detector_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_SEEK,
        ST_ABOVE,
        ST_BELOW
    } state_t;

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int CW = $clog2(CONFIRM + 1);
    localparam state_t RESET_STATE = (WARMUP == 0) ? ST_SEEK : ST_WARMUP;
    localparam logic [1:0] TREND_ABOVE = 2'b01;
    localparam logic [1:0] TREND_BELOW = 2'b10;
    localparam logic signed [16:0] HYST_POS = {1'b0, HYST};
    localparam logic signed [16:0] HYST_NEG = -HYST_POS;

    state_t        state_q, state_d;
    logic [WW-1:0] warmCnt_q, warmCnt_d;
    logic [CW-1:0] upCnt_q, upCnt_d;
    logic [CW-1:0] dnCnt_q, dnCnt_d;
    logic          outValid_q, outValid_d;
    logic [15:0]   diff_q, diff_d;
    logic [1:0]    trend_q, trend_d;
    logic          crossUp_q, crossUp_d;
    logic          crossDn_q, crossDn_d;
    logic [15:0]   eventCnt_q, eventCnt_d;

    logic signed [16:0] diff17;
    logic [15:0]        diffSat;
    logic               isAbove;
    logic               isBelow;
    logic [CW-1:0]      upInc;
    logic [CW-1:0]      dnInc;
    logic [15:0]        eventInc;

    // Bits 16 and 15 disagree exactly when the 17-bit difference leaves the 16-bit signed range.
    always_comb begin
        diff17   = $signed({1'b0, bus.price_in}) - $signed({1'b0, bus.sma_in});
        isAbove  = diff17 > HYST_POS;
        isBelow  = diff17 < HYST_NEG;
        diffSat  = diff17[15:0];
        if (diff17[16] != diff17[15]) begin
            diffSat = diff17[16] ? 16'h8000 : 16'h7FFF;
        end
        upInc    = upCnt_q + 1'b1;
        dnInc    = dnCnt_q + 1'b1;
        eventInc = (eventCnt_q == 16'hFFFF) ? eventCnt_q : eventCnt_q + 16'd1;
    end

    always_comb begin
        state_d    = state_q;
        warmCnt_d  = warmCnt_q;
        upCnt_d    = upCnt_q;
        dnCnt_d    = dnCnt_q;
        outValid_d = 1'b0;
        diff_d     = diff_q;
        trend_d    = trend_q;
        crossUp_d  = 1'b0;
        crossDn_d  = 1'b0;
        eventCnt_d = eventCnt_q;

        if (bus.in_valid) begin
            if (state_q != ST_WARMUP) begin
                outValid_d = 1'b1;
                diff_d     = diffSat;
            end
            case (state_q)
                ST_WARMUP: begin
                    if (warmCnt_q == WW'(WARMUP - 1)) begin
                        state_d   = ST_SEEK;
                        warmCnt_d = '0;
                    end else begin
                        warmCnt_d = warmCnt_q + 1'b1;
                    end
                end
                // Initial side establishment: no pulse, no event count.
                ST_SEEK: begin
                    if (isAbove) begin
                        dnCnt_d = '0;
                        if (upInc == CW'(CONFIRM)) begin
                            state_d = ST_ABOVE;
                            trend_d = TREND_ABOVE;
                            upCnt_d = '0;
                        end else begin
                            upCnt_d = upInc;
                        end
                    end else if (isBelow) begin
                        upCnt_d = '0;
                        if (dnInc == CW'(CONFIRM)) begin
                            state_d = ST_BELOW;
                            trend_d = TREND_BELOW;
                            dnCnt_d = '0;
                        end else begin
                            dnCnt_d = dnInc;
                        end
                    end else begin
                        upCnt_d = '0;
                        dnCnt_d = '0;
                    end
                end
                ST_ABOVE: begin
                    if (!isBelow) begin
                        dnCnt_d = '0;
                    end else if (dnInc == CW'(CONFIRM)) begin
                        state_d    = ST_BELOW;
                        trend_d    = TREND_BELOW;
                        dnCnt_d    = '0;
                        crossDn_d  = 1'b1;
                        eventCnt_d = eventInc;
                    end else begin
                        dnCnt_d = dnInc;
                    end
                end
                ST_BELOW: begin
                    if (!isAbove) begin
                        upCnt_d = '0;
                    end else if (upInc == CW'(CONFIRM)) begin
                        state_d    = ST_ABOVE;
                        trend_d    = TREND_ABOVE;
                        upCnt_d    = '0;
                        crossUp_d  = 1'b1;
                        eventCnt_d = eventInc;
                    end else begin
                        upCnt_d = upInc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            warmCnt_q  <= '0;
            upCnt_q    <= '0;
            dnCnt_q    <= '0;
            outValid_q <= 1'b0;
            diff_q     <= '0;
            trend_q    <= '0;
            crossUp_q  <= 1'b0;
            crossDn_q  <= 1'b0;
            eventCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warmCnt_q  <= warmCnt_d;
            upCnt_q    <= upCnt_d;
            dnCnt_q    <= dnCnt_d;
            outValid_q <= outValid_d;
            diff_q     <= diff_d;
            trend_q    <= trend_d;
            crossUp_q  <= crossUp_d;
            crossDn_q  <= crossDn_d;
            eventCnt_q <= eventCnt_d;
        end
    end

    assign bus.out_valid   = outValid_q;
    assign bus.diff_out    = diff_q;
    assign bus.trend       = trend_q;
    assign bus.cross_up    = crossUp_q;
    assign bus.cross_down  = crossDn_q;
    assign bus.event_count = eventCnt_q;

endmodule
